// File: rtl/bcd_pkg.sv
// Shared types and digit helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } b2b_state_t;

  // Double-dabble correction applied before each shift.
  function automatic logic [DIGIT_W-1:0] add3_if_ge5(input logic [DIGIT_W-1:0] d);
    return (d >= DIGIT_W'(5)) ? d + DIGIT_W'(3) : d;
  endfunction

  function automatic logic [DIGIT_W-1:0] ex3_of(input logic [DIGIT_W-1:0] d);
    return d + DIGIT_W'(3);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the double-dabble correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj_c
);

  assign adj_c = add3_if_ge5(digit);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready on both sides.
// Define BIN2BCD_EX3_OUT_EN to emit each result digit as Excess-3 instead of 8421 BCD.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          in_bin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                      busy
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  // The largest binary operand must fit in the available decimal digits.
  if ((64'(10) ** DIGITS) <= ((64'(1) << BIN_W) - 64'(1))) begin : g_param_check
    $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  b2b_state_t         state;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   adj_c;
  logic [SR_W-1:0]    shift_c;
  logic [BCD_W-1:0]   result_c;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    bcd_digit_adj u_adj (
      .digit (bcd_sr[g*DIGIT_W +: DIGIT_W]),
      .adj_c (adj_c[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Corrected digits and remaining binary shift left as one register; binary MSB enters units LSB.
  assign shift_c = {adj_c, bin_sr} << 1;

  always_comb begin
    result_c = shift_c[SR_W-1 -: BCD_W];
`ifdef BIN2BCD_EX3_OUT_EN
    for (int i = 0; i < int'(DIGITS); i++) begin
      result_c[i*DIGIT_W +: DIGIT_W] = ex3_of(shift_c[BIN_W + i*DIGIT_W +: DIGIT_W]);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bin_sr    <= '0;
      bcd_sr    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            bin_sr   <= in_bin;
            bcd_sr   <= '0;
            cnt      <= '0;
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= shift_c;
          cnt              <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            out_bcd   <= result_c;
          end
        end
        DONE: begin
          // Result is held until downstream takes it.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: decimal reference model, decoupled result monitor.
module tb_bin2bcd_seq;

  localparam int unsigned BIN_W  = 8;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned BCD_W  = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BIN_W-1:0] in_bin = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [BCD_W-1:0] out_bcd;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [BCD_W-1:0] exp_q[$];
  int               lat_q[$];
  bit               prev_valid = 1'b0;
  bit               rand_bp = 1'b0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Decimal digits by plain division; Excess-3 variant adds 3 per digit.
  function automatic logic [BCD_W-1:0] ref_bcd(input int unsigned v);
    logic [BCD_W-1:0] r;
    int unsigned x;
    int unsigned d;
    r = '0;
    x = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = x % 10;
`ifdef BIN2BCD_EX3_OUT_EN
      d = d + 3;
`endif
      r[i*4 +: 4] = 4'(d);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on each rising out_valid, result on each output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid) begin
        if (lat_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency", longint'(cyc - lat_q.pop_front()), longint'(BIN_W));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else chk("result", longint'(out_bcd), longint'(exp_q.pop_front()));
        chk("in_ready_in_done", longint'(in_ready), 0);
      end
    end
    prev_valid = out_valid;
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input int unsigned v, input bit push, output int acc);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      acc = cyc;
      return;
    end
    in_valid = 1'b1;
    in_bin   = BIN_W'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc = cyc;
    if (push) begin
      exp_q.push_back(ref_bcd(v));
      lat_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", longint'(exp_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int last;
    int k;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", longint'(in_ready), 1);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_out_bcd", longint'(out_bcd), 0);
    chk("reset_busy", longint'(busy), 0);

    // Zero and maximum operands.
    send(0, 1'b1, acc);
    drain();
    send(255, 1'b1, acc);
    drain();
    chk("ref_model_255", longint'(ref_bcd(255)),
`ifdef BIN2BCD_EX3_OUT_EN
        longint'(12'h588)
`else
        longint'(12'h255)
`endif
    );

    // Backpressure: result of 99 must be held.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(99, 1'b1, acc);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("hold_reached_valid", longint'(out_valid), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_out_valid", longint'(out_valid), 1);
      chk("hold_out_bcd", longint'(out_bcd), longint'(ref_bcd(99)));
      chk("hold_in_ready", longint'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // in_valid during SHIFT is ignored.
    send(128, 1'b1, acc);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_bin   = 8'd7;
    chk("ignore_in_ready", longint'(in_ready), 0);
    chk("ignore_busy", longint'(busy), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ignore_still_busy", longint'(busy), 1);
    drain();
    chk("ignore_no_extra_latency", longint'(lat_q.size()), 0);

    // Reset in the middle of SHIFT.
    send(42, 1'b0, acc);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_out_bcd", longint'(out_bcd), 0);
    chk("midrst_busy", longint'(busy), 0);
    repeat (12) @(negedge clk);
    chk("midrst_no_output", longint'(out_valid), 0);

    // Random operands under random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 255), 1'b1, acc);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // Exhaustive back-to-back sweep; accepts must be exactly BIN_W+2 apart.
    last = 0;
    for (int v = 0; v < 256; v++) begin
      send(v, 1'b1, acc);
      if (v > 0) chk("sweep_spacing", longint'(acc - last), longint'(BIN_W + 2));
      last = acc;
    end
    drain();
    chk("final_latency_queue", longint'(lat_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
